// File: rtl/mlb_cfg_pkg.sv
// Shared types and geometry helpers for the MAC config-chain loader.
package mlb_cfg_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_SHIFT = 2'd1,
    CFG_DRAIN = 2'd2
  } cfg_state_t;

  // The chain must hold a whole number of words, at least one.
  function automatic bit cfg_geometry_ok(input int chain_len, input int word_w);
    return (word_w > 0) && (chain_len >= word_w) && ((chain_len % word_w) == 0);
  endfunction

  function automatic int cfg_idx_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Config-word and readback-word valid/ready streams between host and loader.
interface config_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;

  modport master (
    output cfg_data, cfg_valid, rb_ready,
    input  cfg_ready, rb_data, rb_valid
  );

  modport slave (
    input  cfg_data, cfg_valid, rb_ready,
    output cfg_ready, rb_data, rb_valid
  );
endinterface

// File: rtl/cfg_word_shifter.sv
// TX parallel-in/serial-out and RX serial-in/parallel-out for one config word.
// Both sides move in lockstep, so a single bit index marks the word boundary.
module cfg_word_shifter
  import mlb_cfg_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              ser_in,
  output logic              ser_out,
  output logic              occupied,
  output logic              last_bit,
  output logic [WORD_W-1:0] rx_word
);
  localparam int IDX_W = cfg_idx_width(WORD_W);

  logic [WORD_W-1:0] tx_sr_reg;
  logic              occupied_reg;
  logic [IDX_W-1:0]  idx_reg;

  assign last_bit = (idx_reg == IDX_W'(WORD_W - 1));
  assign ser_out  = tx_sr_reg[0];
  assign occupied = occupied_reg;

  // A load in the same cycle as the final shift refills the register seamlessly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_sr_reg    <= '0;
      occupied_reg <= 1'b0;
      idx_reg      <= '0;
    end else begin
      if (load) begin
        tx_sr_reg    <= load_data;
        occupied_reg <= 1'b1;
      end else if (shift) begin
        tx_sr_reg <= tx_sr_reg >> 1;
        if (last_bit) begin
          occupied_reg <= 1'b0;
        end
      end
      if (shift) begin
        idx_reg <= last_bit ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // The completed word includes the tail bit arriving this cycle.
  generate
    if (WORD_W == 1) begin : g_rx_bit
      assign rx_word = ser_in;
    end else begin : g_rx_word
      logic [WORD_W-2:0] rx_sr_reg;
      logic [WORD_W-2:0] rx_sr_next;
      if (WORD_W == 2) begin : g_two
        assign rx_sr_next = ser_in;
      end else begin : g_wide
        assign rx_sr_next = {ser_in, rx_sr_reg[WORD_W-2:1]};
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rx_sr_reg <= '0;
        end else if (shift) begin
          rx_sr_reg <= rx_sr_next;
        end
      end
      assign rx_word = {ser_in, rx_sr_reg};
    end
  endgenerate

endmodule

// File: rtl/config_chain_loader.sv
// Head-of-column config chain loader: serializes config words into the scan
// chain while capturing the previous chain contents as readback words.
module config_chain_loader
  import mlb_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  config_chain_loader_if.slave  bus,
  output logic                  config_en,
  output logic                  config_in,
  input  logic                  config_out
);
  localparam int N_WORDS = CHAIN_LEN / WORD_W;
  localparam int BIT_W   = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W  = $clog2(N_WORDS + 1);

  generate
    if (!cfg_geometry_ok(CHAIN_LEN, WORD_W)) begin : g_bad_geometry
      $error("config_chain_loader: CHAIN_LEN must be a non-zero multiple of WORD_W");
    end
  endgenerate

  cfg_state_t        state_reg;
  cfg_state_t        state_next;
  logic              done_reg;
  logic              done_next;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [WCNT_W-1:0] words_acc_reg;
  logic [WORD_W-1:0] rb_data_reg;
  logic              rb_valid_reg;

  logic              tx_bit;
  logic              occupied;
  logic              last_bit;
  logic [WORD_W-1:0] rx_word;
  logic              in_shift;
  logic              rb_stall;
  logic              cfg_accept;
  logic              rb_fire;
  logic              last_shift;

  cfg_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (cfg_accept),
    .load_data (bus.cfg_data),
    .shift     (config_en),
    .ser_in    (config_out),
    .ser_out   (tx_bit),
    .occupied  (occupied),
    .last_bit  (last_bit),
    .rx_word   (rx_word)
  );

  assign in_shift = (state_reg == CFG_SHIFT);
  // Completing a new RX word would overwrite an unconsumed one, so hold the chain.
  assign rb_stall   = occupied && last_bit && rb_valid_reg && !bus.rb_ready;
  assign config_en  = in_shift && occupied && !rb_stall;
  assign config_in  = config_en & tx_bit;
  assign bus.cfg_ready = in_shift && (words_acc_reg < WCNT_W'(N_WORDS)) &&
                         (!occupied || (config_en && last_bit));
  assign cfg_accept = bus.cfg_valid && bus.cfg_ready;
  assign rb_fire    = rb_valid_reg && bus.rb_ready;
  assign last_shift = config_en && (bit_cnt_reg == BIT_W'(CHAIN_LEN - 1));

  assign busy        = (state_reg != CFG_IDLE);
  assign done        = done_reg;
  assign bus.rb_data  = rb_data_reg;
  assign bus.rb_valid = rb_valid_reg;

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      CFG_IDLE: begin
        if (start) begin
          state_next = CFG_SHIFT;
        end
      end
      CFG_SHIFT: begin
        if (last_shift) begin
          state_next = CFG_DRAIN;
        end
      end
      CFG_DRAIN: begin
        // Only the final readback word can be pending once shifting is over.
        if (rb_fire) begin
          state_next = CFG_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= CFG_IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg   <= '0;
      words_acc_reg <= '0;
    end else if ((state_reg == CFG_IDLE) && start) begin
      bit_cnt_reg   <= '0;
      words_acc_reg <= '0;
    end else begin
      if (config_en) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if (cfg_accept) begin
        words_acc_reg <= words_acc_reg + 1'b1;
      end
    end
  end

  // A completion in the same cycle as a handshake keeps rb_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_data_reg  <= '0;
      rb_valid_reg <= 1'b0;
    end else if (config_en && last_bit) begin
      rb_data_reg  <= rx_word;
      rb_valid_reg <= 1'b1;
    end else if (rb_fire) begin
      rb_valid_reg <= 1'b0;
    end
  end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Serial-configuration transmitter for the MAC-unit configuration scan chain. It accepts parallel configuration words over a valid/ready stream and serializes them onto the chain's `config_in`/`config_en` pins. In the same shift it captures the previous chain contents from `config_out` and returns them as parallel readback words. One instance sits at the head of each MAC-array column's config chain, between the host/config controller and the first MAC unit.

## Interface

Parameters:
- `CHAIN_LEN`, 64: total bits in the attached chain; must be a multiple of `WORD_W`, with an elaboration-time check.
- `WORD_W`, 8: width of config and readback words.
- `N_WORDS`, localparam: `CHAIN_LEN/WORD_W`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a full-chain load; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the load and all readback words are complete.
- `cfg_data`  in  `WORD_W`  next configuration word.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  block accepts a word this cycle.
- `rb_data`  out  `WORD_W`  readback word, holding the old chain contents.
- `rb_valid`  out  1  `rb_data` is valid.
- `rb_ready`  in  1  consumer accepts the readback word.
- `config_en`  out  1  chain shift enable; one bit shifts per cycle while high.
- `config_in`  out  1  serial bit into the chain head.
- `config_out`  in  1  serial bit from the chain tail.

## Operation

- **FSM states:**
  - IDLE goes to SHIFT on `start`.
  - SHIFT goes to DRAIN after bit `CHAIN_LEN-1` shifts.
  - DRAIN goes to IDLE on the final `rb` handshake, and pulses `done` on the next cycle.
- **TX shift register:** holds `WORD_W` bits plus an occupied flag. Words shift LSB first, and word 0 is shifted first.
- **Ready/accept rule:** `cfg_ready = (state==SHIFT) && words_accepted<N_WORDS && (!occupied || last bit of the current word shifts this cycle)`. This allows back-to-back words with no bubble.
- **Shift enable:** `config_en = (state==SHIFT) && occupied && !rb_stall`. `config_en` is combinational from registered state and `rb_ready`.
  - `rb_stall` = the RX word completes this cycle && `rb_valid` && `!rb_ready`.
- **Serial data:** `config_in` = TX shift-register bit 0. It is valid whenever `config_en` is high, and is 0 otherwise.
- **Readback capture:**
  - On each shift, `config_out` (the tail value before the shift) enters the RX shift register at its MSB, shifting right.
  - After `WORD_W` shifts the word moves to `rb_data` and `rb_valid` is set; `rb_valid` holds until `rb_ready`.
  - Readback word k holds the old chain bits that exit the tail in order, LSB first.
- **Counters:** the bit counter is `$clog2(CHAIN_LEN+1)` bits wide. The word counters run 0..`N_WORDS`. There is no wrap: bits beyond `CHAIN_LEN` are never shifted, and `cfg_ready` stays 0 after `N_WORDS` words.
- **Stalls:** `cfg_valid` low stalls shifting; `config_en` stays 0 and chain state is preserved. A readback stall also halts TX.
- **`start` while `busy`:** ignored and not queued.
- **Reset mid-load:**
  - All state clears immediately, and `config_en` drops asynchronously.
  - Chain contents are then partial and undefined; the host must re-run a full load.
  - Any readback word not yet handshaken is lost.

## Timing

- **Reset values:** `busy`, `done`, `cfg_ready`, `rb_valid`, `config_en` and `config_in` are 0; `rb_data` is 0.
- **Full-throughput schedule** (`start` in cycle 0, `cfg_valid`=1 and `rb_ready`=1 throughout):
  - `busy` and `cfg_ready` go high in cycle 1.
  - Word 0 is accepted in cycle 1.
  - Shifts occur in cycles 2..`CHAIN_LEN+1`.
  - Readback word k is valid in cycle `2+(k+1)*WORD_W`.
  - `done` pulses and `busy` falls in cycle `CHAIN_LEN+3`.
- **Each stall cycle** (from either `cfg` or `rb`) adds exactly one cycle.
- **Simultaneous final events:** a word acceptance and the last-bit shift of the previous word may occur in the same cycle. An `rb` handshake and the next RX word completion may also occur in the same cycle; neither stalls.

## Structure

- **Package `mlb_cfg_pkg`:** holds the state enum (`CFG_IDLE`, `CFG_SHIFT`, `CFG_DRAIN`) and the `WORD_W`/`CHAIN_LEN` legality checks.
- **Sub-module `cfg_word_shifter`:** a natural split, parameterized by `WORD_W`. It provides the TX PISO, the RX SIPO and the per-word bit counter. The FSM, word counters and handshakes stay in the top level.

## Test plan

- **Basic load and readback:**
  - Setup: `CHAIN_LEN`=16, `WORD_W`=8, chain model preset so its tail emits 0x34 then 0x12, full throughput.
  - Stimulus: load 0xA5 then 0x3C.
  - Required: the chain then holds the 0xA5/0x3C bit order; readback returns 0x34 then 0x12; `done` in cycle 19.
- **Config-side stalls:** drop `cfg_valid` for 3 cycles between words. Required: `config_en` low for exactly those 3 cycles, `done` in cycle 22, chain contents unchanged versus the basic load.
- **Readback backpressure:** hold `rb_ready` low for 5 cycles when the first readback word appears. Required: `rb_data`=0x34 stable; shifting halts when the second word completes, or never halts if the stall ends first. Final results match the basic load.
- **`start` while busy:** pulse `start` mid-load. Required: ignored; exactly 16 shifts occur and one `done` pulse.
- **Reset mid-load:** assert `reset` after 5 shifts. Required: all outputs go to 0 asynchronously; a subsequent full load succeeds with correct readback of the partially shifted chain.
- **Excess words:** offer a third word with `cfg_valid` held high. Required: `cfg_ready` never asserts for it; `config_en` stays 0 after 16 shifts.
